// File: rtl/serial_word_feeder_pkg.sv
// Shared constants and state encoding for the bit-serial word path.
// Used by the feeder, the downstream deserializer and the benches.
package serial_pkg;

    localparam int SER_WIDTH = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_CLR   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        SHIFT = S_SHIFT,
        CLR   = S_CLR
    } state_e;

    // bit count index width; never below one bit
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_word_feeder_if.sv
// Parallel word handshake plus the serial framing outputs of the feeder.
// master is the word producer, slave is the feeder.
interface serial_word_feeder_if
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) ();

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_bit;
    logic             ser_clr;
    logic             ser_last;
    logic             busy;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  ser_bit,
        input  ser_clr,
        input  ser_last,
        input  busy
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output ser_bit,
        output ser_clr,
        output ser_last,
        output busy
    );

endinterface

// File: rtl/serial_word_feeder.sv
// Serializes parallel words LSB first and clears the downstream
// two's-complement converter before every word.
module serial_word_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) (
    input  logic                 t_clk,
    input  logic                 r,
    serial_word_feeder_if.slave  bus
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state;
    state_e           state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_n;

    logic at_last;
    logic accept;

    logic ser_bit_q;
    logic ser_clr_q;
    logic ser_last_q;
    logic busy_q;

    assign at_last = (cnt == LAST);

    assign bus.din_ready = ~r & ((state == IDLE) |
                                 ((state == SHIFT) & at_last));

    assign accept = bus.din_valid & bus.din_ready;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sreg_n  = sreg;
        unique case (1'b1)
            (state == IDLE): begin
                if (accept) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                    sreg_n  = bus.din;
                end
            end
            (state == SHIFT): begin
                if (at_last) begin
                    cnt_n = '0;
                    if (accept) begin
                        // next word waits one CLR cycle
                        state_n = CLR;
                        sreg_n  = bus.din;
                    end else begin
                        state_n = IDLE;
                        sreg_n  = '0;
                    end
                end else begin
                    cnt_n  = cnt + CW'(1);
                    sreg_n = sreg >> 1;
                end
            end
            (state == CLR): begin
                state_n = SHIFT;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                sreg_n  = '0;
            end
        endcase
    end

    always_ff @(posedge t_clk) begin
        if (r) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sreg  <= sreg_n;
        end
    end

    // outputs registered from next-state values
    always_ff @(posedge t_clk) begin
        if (r) begin
            ser_bit_q  <= 1'b0;
            ser_clr_q  <= 1'b1;
            ser_last_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ser_bit_q  <= (state_n == SHIFT) & sreg_n[0];
            ser_clr_q  <= (state_n != SHIFT);
            ser_last_q <= (state_n == SHIFT) & (cnt_n == LAST);
            busy_q     <= (state_n == SHIFT);
        end
    end

    assign bus.ser_bit  = ser_bit_q;
    assign bus.ser_clr  = ser_clr_q;
    assign bus.ser_last = ser_last_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder with a converter model and a
// scoreboard of expected converter words.
module tb_serial_word_feeder;
    import serial_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic r;

    always #5 clk = ~clk;

    serial_word_feeder_if #(.WIDTH(W)) bus ();

    serial_word_feeder #(.WIDTH(W)) dut (
        .t_clk (clk),
        .r     (r),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] sb[$];
    logic         seen = 1'b0;
    logic         y;
    logic [W-1:0] acc = '0;
    logic [W-1:0] exp_w;
    int           idx = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // converter model: y = i ^ seen, seen cleared by ser_clr
    always @(negedge clk) begin
        if (bus.busy === 1'b1) begin
            y = bus.ser_bit ^ seen;
            if (idx < W) acc[idx] = y;
            idx++;
            if (bus.ser_last === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $error("FAIL spurious_word: observed %0h expected none",
                           acc);
                end else begin
                    exp_w = sb.pop_front();
                    chk("conv_word", 32'(acc), 32'(exp_w));
                end
                idx = 0;
            end
        end else begin
            idx = 0;
        end
        seen = bus.ser_clr ? 1'b0 : (seen | bus.ser_bit);
    end

    task automatic chk_idle(input string tag, input logic rdy);
        chk({tag, "_clr"},   32'(bus.ser_clr),   32'd1);
        chk({tag, "_bit"},   32'(bus.ser_bit),   32'd0);
        chk({tag, "_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_last"},  32'(bus.ser_last),  32'd0);
        chk({tag, "_ready"}, 32'(bus.din_ready), 32'(rdy));
    endtask

    // starts just after the accept edge, ends just after the last-bit edge
    task automatic shift_word(input logic [W-1:0] d);
        for (int k = 0; k < W; k++) begin
            smp();
            chk($sformatf("bit%0d_%0h", k, d), 32'(bus.ser_bit), 32'(d[k]));
            chk($sformatf("clr%0d", k), 32'(bus.ser_clr), 32'd0);
            chk($sformatf("busy%0d", k), 32'(bus.busy), 32'd1);
            chk($sformatf("last%0d", k), 32'(bus.ser_last),
                32'(k == W - 1));
            chk($sformatf("rdy%0d", k), 32'(bus.din_ready),
                32'(k == W - 1));
            cyc();
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic [W-1:0] e);
        bus.din       = d;
        bus.din_valid = 1'b1;
        sb.push_back(e);
        smp();
        chk("accept_ready", 32'(bus.din_ready), 32'd1);
        cyc();
        bus.din_valid = 1'b0;
        shift_word(d);
        smp();
        chk_idle("post_word", 1'b1);
        cyc();
    endtask

    initial begin
        r             = 1'b1;
        bus.din       = 8'hAA;
        bus.din_valid = 1'b1;

        repeat (2) begin
            cyc();
            smp();
            chk_idle("reset", 1'b0);
        end
        cyc();
        r             = 1'b0;
        bus.din_valid = 1'b0;
        smp();
        chk_idle("after_reset", 1'b1);
        repeat (2) begin
            cyc();
            smp();
            chk("no_word_busy", 32'(bus.busy), 32'd0);
        end
        cyc();

        send(8'h06, 8'hFA);

        bus.din       = 8'h01;
        bus.din_valid = 1'b1;
        sb.push_back(8'hFF);
        cyc();
        bus.din = 8'h80;
        sb.push_back(8'h80);
        shift_word(8'h01);
        bus.din_valid = 1'b0;
        smp();
        chk_idle("b2b_clr", 1'b0);
        cyc();
        shift_word(8'h80);
        smp();
        chk_idle("b2b_end", 1'b1);
        cyc();

        send(8'h00, 8'h00);
        send(8'hFF, 8'h01);
        send(8'h80, 8'h80);

        bus.din       = 8'h3C;
        bus.din_valid = 1'b1;
        sb.push_back(8'hC4);
        cyc();
        bus.din_valid = 1'b0;
        repeat (3) begin
            smp();
            cyc();
        end
        r = 1'b1;
        sb.delete();
        smp();
        chk("midreset_ready", 32'(bus.din_ready), 32'd0);
        cyc();
        r = 1'b0;
        smp();
        chk_idle("midreset", 1'b1);
        cyc();
        send(8'h05, 8'hFB);

        for (int g = 0; g < 5; g++) begin
            bus.din = (g % 2 == 0) ? 8'h5A : 8'hA5;
            smp();
            chk_idle($sformatf("gap%0d", g), 1'b1);
            cyc();
        end

        smp();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Upstream stage of the bit-serial two's-complement converter (`invert`).
- Accepts parallel words over a valid/ready handshake and shifts each word out LSB first on `ser_bit`, which drives the converter's `i` input.
- Drives the converter's `r` input through `ser_clr`, so the "first 1 seen" state is cleared before every word.
- Provides word framing (`ser_last`, `busy`) for downstream capture.

Parameters:
- WIDTH, 8, bits per word; legal range is 2 and above.

Ports:
- t_clk  input  1  clock; all state updates on the rising edge.
- r  input  1  synchronous active-high reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word.
- din_ready  output  1  feeder accepts din at this edge.
- ser_bit  output  1  serial data, LSB first; connects to converter `i`.
- ser_clr  output  1  converter clear; connects to converter `r`.
- ser_last  output  1  ser_bit is the MSB of the current word.
- busy  output  1  a word is being shifted.

Behaviour:
- Clock and reset: one clock, t_clk. Reset r is synchronous and active-high. r=1 at an edge forces IDLE.
- Reset values (first cycle after an edge with r=1):
  - ser_bit=0, ser_clr=1, ser_last=0, busy=0.
  - Counter=0, shift register=0.
- din_ready is combinational: ~r & (state==IDLE | (state==SHIFT & cnt==WIDTH-1)). It is therefore 0 whenever r=1.
- Accept: din_valid & din_ready at an edge. din is captured into the shift register at that edge. din is ignored at all other edges.
- State machine:
  - IDLE:
    - Outputs: ser_clr=1, ser_bit=0, busy=0.
    - On accept: go to SHIFT with cnt=0. The first bit appears in the cycle after the accept edge (latency 1).
    - The converter has already been cleared by ser_clr=1 during the accept cycle.
  - SHIFT:
    - Outputs: ser_clr=0, busy=1, ser_bit=sreg[0], ser_last=(cnt==WIDTH-1).
    - Each edge shifts sreg right by 1 and increments cnt.
    - At cnt==WIDTH-1 with accept: go to CLR and load the new word.
    - At cnt==WIDTH-1 without accept: go to IDLE.
  - CLR:
    - Exactly one cycle with ser_clr=1, ser_bit=0, busy=0, din_ready=0.
    - Unconditionally goes to SHIFT with cnt=0.
- All outputs except din_ready are registered. No combinational path from din or din_valid to ser_*.
- Every word is preceded by at least one ser_clr=1 cycle. Back-to-back words therefore have exactly one gap cycle, giving throughput WIDTH/(WIDTH+1).
- Counter width: $clog2(WIDTH). Wrap-around is handled only by the state transition; the counter never free-runs.
- Reset mid-word: the word in flight is dropped with no partial completion. The next cycle shows reset values, and a new accept proceeds normally.
- Simultaneous r=1 with din_valid=1: reset wins and no word is captured (din_ready=0).
- din changing while not accepted has no effect on the outputs.
- End-to-end property: the serial output of the converter, reassembled LSB first over the SHIFT cycles, equals (-din) mod 2^WIDTH.

Decomposition:
- Shared package `serial_pkg` holds:
  - the WIDTH default constant (8);
  - state encoding localparams S_IDLE, S_SHIFT, S_CLR (2-bit);
  - a counter-width helper.
- The downstream deserializer and the benches reuse this package.
- No sub-module: the shift register, counter and 3-state FSM stay in one module.

Test Plan:
- Reset: hold r=1 for 2 cycles with din_valid=1, din=8'hAA. Required: ser_clr=1, ser_bit=0, busy=0, din_ready=0 throughout, and no word shifted afterwards unless re-presented.
- Single word: din=8'h06 in IDLE.
  - ser_bit=0,1,1,0,0,0,0,0 over the next 8 cycles, ser_clr=0, ser_last only on the 8th.
  - Converter y reassembles to 8'hFA, then IDLE with ser_clr=1.
- Back-to-back: din_valid held, 8'h01 then 8'h80.
  - Second word accepted on the last-bit cycle of the first.
  - Exactly one CLR cycle follows (ser_clr=1).
  - Converter outputs reassemble to 8'hFF then 8'h80.
- Boundaries: words 8'h00, 8'hFF, 8'h80. Converter results must be 8'h00, 8'h01, 8'h80. For 8'h00, ser_bit stays 0 for all 8 bits.
- Reset mid-word: pulse r=1 after 3 bits of 8'h3C.
  - Next cycle shows reset values and the word is dropped.
  - Then 8'h05 is accepted and yields converter result 8'hFB.
- Idle gaps: din_valid low for 5 cycles while din toggles. Required: ser_clr=1 held, no ser_bit activity, din_ready=1.
